ifetch_buffer: RTL and testbench

Instruction prefetch queue between the instruction memory and the execute stage. Keeps its own fetch PC and reads one instruction word per cycle from the combinational instruction memory. Buffers fetched instructions, each with its PC, in a small FIFO. Delivers them to execute over a valid/ready handshake, and flushes and restarts when execute redirects control flow (taken branch or jump).

---
 rtl/ifetch_buffer.sv | 76 +++++++
 tb/tb_ifetch_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction prefetch queue: fetches one word per cycle from a combinational
// instruction memory into a small FIFO of {pc, ins} and hands it to execute.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rstd,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [PC_W-1:0]              imem_data,
  output logic [PC_W-1:0]              ins,
  output logic [PC_W-1:0]              ins_pc,
  output logic                         ins_valid,
  input  logic                         ins_ready,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]  fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [PC_W-1:0]  ins_mem [DEPTH];
  logic             pop;
  logic             push;

  // count never exceeds DEPTH, so "not full" is the same as count < DEPTH
  assign pop       = ins_valid & ins_ready;
  assign push      = ~redirect & ((count != FULL) | pop);
  assign ins_valid = (count != '0);
  assign imem_addr = fetch_pc;
  assign ins       = ins_valid ? ins_mem[rd_ptr] : '0;
  assign ins_pc    = ins_valid ? pc_mem[rd_ptr]  : '0;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      fetch_pc <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Flush: a head popped this cycle is simply dropped with the rest
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + PC_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: table of per-cycle vectors plus a queue model of
// the fetch stream, and hand-written reset sequences.
module tb_ifetch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rstd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  ifetch_buffer #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: imem[k] = k + 0x100
  always_comb imem_data = imem_addr + 32'h100;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
    logic [31:0] eaddr;
  } vec_t;

  int          nvec = 0;
  int          nmis = 0;
  logic [31:0] mq[$];
  logic [31:0] mfetch = 32'h0;
  logic [31:0] last_acc = 32'h0;
  bit          have_last = 1'b0;
  vec_t        v[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mfetch    = 32'h0;
    have_last = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'b0, ins_valid}, 32'h0);
    check({tag, "_count"}, {29'b0, count}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_ins"}, ins, 32'h0);
    check({tag, "_ins_pc"}, ins_pc, 32'h0);
  endtask

  // Called just after a falling edge: drive, update model, clock, compare.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc,
                      input logic [31:0] ecnt, input logic [31:0] eaddr);
    bit          mpop;
    logic [1:0]  pdiff;
    ins_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    mpop = (mq.size() != 0) && rdy;
    if (mpop) begin
      check("pop_pc", ins_pc, mq[0]);
      check("pop_ins", ins, mq[0] + 32'h100);
      if (have_last) check("pc_seq", ins_pc, last_acc + 32'h1);
      last_acc  = ins_pc;
      have_last = 1'b1;
    end
    if (rd) begin
      mq.delete();
      mfetch    = rpc;
      have_last = 1'b0;
    end else begin
      if (mpop) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back(mfetch);
        mfetch = mfetch + 32'h1;
      end
    end
    @(posedge clk);
    #1;
    check("tbl_valid", {31'b0, ins_valid}, {31'b0, ev});
    check("tbl_count", {29'b0, count}, ecnt);
    check("tbl_addr", imem_addr, eaddr);
    if (ev) check("tbl_ins_pc", ins_pc, epc);
    check("mdl_count", {29'b0, count}, mq.size());
    check("mdl_addr", imem_addr, mfetch);
    check("mdl_ins_pc", ins_pc, (mq.size() != 0) ? mq[0] : 32'h0);
    check("mdl_ins", ins, (mq.size() != 0) ? mq[0] + 32'h100 : 32'h0);
    if (count > 3'(DEPTH)) check("cnt_le_depth", {29'b0, count}, DEPTH);
    if (count < 3'(DEPTH)) begin
      pdiff = dut.wr_ptr - dut.rd_ptr;
      check("ptr_inv", {30'b0, pdiff}, {30'b0, count[1:0]});
    end
    @(negedge clk);
  endtask

  initial begin
    v[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'd1, 32'h1};
    v[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1,        32'd1, 32'h2};
    v[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h2,        32'd1, 32'h3};
    v[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        32'd2, 32'h4};
    v[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        32'd3, 32'h5};
    v[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        32'd4, 32'h6};
    v[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        32'd4, 32'h6};
    v[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h3,        32'd4, 32'h7};
    v[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h3,        32'd4, 32'h7};
    v[9]  = '{1'b1, 1'b1, 32'h20,       1'b0, 32'h0,        32'd0, 32'h20};
    v[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h20,       32'd1, 32'h21};
    v[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h21,       32'd1, 32'h22};
    v[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h21,       32'd2, 32'h23};
    v[13] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        32'd0, 32'hFFFFFFFF};
    v[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 32'd1, 32'h0};
    v[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'd1, 32'h1};
    v[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1,        32'd1, 32'h2};
    v[17] = '{1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        32'd0, 32'h40};
    v[18] = '{1'b1, 1'b1, 32'h50,       1'b0, 32'h0,        32'd0, 32'h50};
    v[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h50,       32'd1, 32'h51};
    v[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h50,       32'd2, 32'h52};

    rstd        = 1'b0;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    #2;
    check_reset_state("reset");

    @(negedge clk);
    rstd = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step(v[i].ready, v[i].redir, v[i].rpc, v[i].ev, v[i].epc, v[i].ecnt, v[i].eaddr);
    end

    // Asynchronous reset mid-cycle with two entries buffered
    check("pre_rst_count", {29'b0, count}, 32'd2);
    #2;
    rstd = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    #1;
    check_reset_state("held_rst");
    model_reset();
    @(negedge clk);
    rstd      = 1'b1;
    ins_ready = 1'b0;

    // Fill with execute stalled, then one pop/push at full
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd1, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd2, 32'h2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd3, 32'h3);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd4, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd4, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1, 32'd4, 32'h5);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1, 32'd4, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
